// File: rtl/approx_add_pipe.sv
// Pipelined lower-part-OR approximate adder (LOA) with runtime approximation depth,
// valid/ready streaming and an error monitor against the exact sum.
module approx_add_pipe #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned STAGES = 2,
   parameter int unsigned KMAX   = 8,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_a,
   input  logic [WIDTH-1:0]           in_b,
   input  logic [$clog2(KMAX+1)-1:0]  in_k,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH:0]             out_sum,
   output logic [WIDTH:0]             out_err,
   input  logic                       stat_clr,
   output logic [WIDTH:0]             err_max,
   output logic [CNT_W-1:0]           err_cnt
);

   localparam int unsigned SEG_W = WIDTH / STAGES;
   localparam int unsigned KW    = $clog2(KMAX + 1);

   logic          advance;
   logic [KW-1:0] k_eff;
   logic [WIDTH:0] res_apx, res_ex;

   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;
   // Approximated bits never exceed segment 0, so k is only needed at the input stage.
   assign k_eff    = (32'(in_k) > KMAX) ? KW'(KMAX) : in_k;

   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      localparam int unsigned Lo = s * SEG_W;

      logic [SEG_W-1:0] seg_a, seg_b;
      logic             ci_apx, ci_ex, vld_src;
      logic [WIDTH:0]   apx_src, ex_src;
      logic [SEG_W:0]   seg_apx, seg_ex;
      logic [WIDTH:0]   apx_d, ex_d, apx_q, ex_q;
      logic             vld_q;

      if (s == 0) begin : g_first
         assign seg_a   = in_a[SEG_W-1:0];
         assign seg_b   = in_b[SEG_W-1:0];
         assign ci_apx  = 1'b0;
         assign ci_ex   = 1'b0;
         assign apx_src = '0;
         assign ex_src  = '0;
         assign vld_src = in_valid;
      end else begin : g_next
         assign seg_a   = g_stage[s-1].g_ops.opa_q[SEG_W-1:0];
         assign seg_b   = g_stage[s-1].g_ops.opb_q[SEG_W-1:0];
         assign ci_apx  = g_stage[s-1].g_ops.capx_q;
         assign ci_ex   = g_stage[s-1].g_ops.cex_q;
         assign apx_src = g_stage[s-1].apx_q;
         assign ex_src  = g_stage[s-1].ex_q;
         assign vld_src = g_stage[s-1].vld_q;
      end

      // Segment ripple add: approximate (OR below k, injected carry) and exact in parallel.
      always_comb begin : p_seg
         logic ca, ce;
         ca      = ci_apx;
         ce      = ci_ex;
         seg_apx = '0;
         seg_ex  = '0;
         for (int unsigned j = 0; j < SEG_W; j++) begin
            if (s == 0 && j < 32'(k_eff)) begin
               seg_apx[j] = seg_a[j] | seg_b[j];
               ca         = (j + 1 == 32'(k_eff)) ? (seg_a[j] & seg_b[j]) : 1'b0;
            end else begin
               seg_apx[j] = seg_a[j] ^ seg_b[j] ^ ca;
               ca         = (seg_a[j] & seg_b[j]) | (ca & (seg_a[j] ^ seg_b[j]));
            end
            seg_ex[j] = seg_a[j] ^ seg_b[j] ^ ce;
            ce        = (seg_a[j] & seg_b[j]) | (ce & (seg_a[j] ^ seg_b[j]));
         end
         seg_apx[SEG_W] = ca;
         seg_ex[SEG_W]  = ce;
      end

      // Merge this segment into the partial sums; the last stage also places the carry-out.
      always_comb begin : p_merge
         apx_d = apx_src;
         ex_d  = ex_src;
         apx_d[Lo +: SEG_W] = seg_apx[SEG_W-1:0];
         ex_d[Lo +: SEG_W]  = seg_ex[SEG_W-1:0];
         if (s == STAGES - 1) begin
            apx_d[WIDTH] = seg_apx[SEG_W];
            ex_d[WIDTH]  = seg_ex[SEG_W];
         end
      end

      // Stage result registers; the whole pipe holds on a stall.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vld_q <= 1'b0;
            apx_q <= '0;
            ex_q  <= '0;
         end else if (advance) begin
            vld_q <= vld_src;
            apx_q <= apx_d;
            ex_q  <= ex_d;
         end
      end

      if (s < STAGES - 1) begin : g_ops
         localparam int unsigned Rem = WIDTH - (s + 1) * SEG_W;

         logic [Rem-1:0] opa_d, opb_d, opa_q, opb_q;
         logic           capx_q, cex_q;

         if (s == 0) begin : g_src0
            assign opa_d = in_a[WIDTH-1:SEG_W];
            assign opb_d = in_b[WIDTH-1:SEG_W];
         end else begin : g_srcn
            assign opa_d = g_stage[s-1].g_ops.opa_q[Rem+SEG_W-1:SEG_W];
            assign opb_d = g_stage[s-1].g_ops.opb_q[Rem+SEG_W-1:SEG_W];
         end

         // Skew registers: only the not-yet-added operand bits travel forward.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               opa_q  <= '0;
               opb_q  <= '0;
               capx_q <= 1'b0;
               cex_q  <= 1'b0;
            end else if (advance) begin
               opa_q  <= opa_d;
               opb_q  <= opb_d;
               capx_q <= seg_apx[SEG_W];
               cex_q  <= seg_ex[SEG_W];
            end
         end
      end
   end

   assign out_valid = g_stage[STAGES-1].vld_q;
   assign res_apx   = g_stage[STAGES-1].apx_q;
   assign res_ex    = g_stage[STAGES-1].ex_q;
   assign out_sum   = res_apx;
   // Injected carry can overshoot, so the error is a true absolute difference.
   assign out_err   = (res_ex >= res_apx) ? (res_ex - res_apx) : (res_apx - res_ex);

   logic [WIDTH:0]   err_max_d, err_max_q;
   logic [CNT_W-1:0] err_cnt_d, err_cnt_q;

   // Statistics next state: clear wins over a coinciding output transfer.
   always_comb begin
      err_max_d = err_max_q;
      err_cnt_d = err_cnt_q;
      if (stat_clr) begin
         err_max_d = '0;
         err_cnt_d = '0;
      end else if (out_valid && out_ready) begin
         if (out_err > err_max_q) err_max_d = out_err;
         if (out_err != '0 && err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
      end
   end

   // Statistics registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_max_q <= '0;
         err_cnt_q <= '0;
      end else begin
         err_max_q <= err_max_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err_max = err_max_q;
   assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_approx_add_pipe.sv
// Self-checking bench for approx_add_pipe: directed cases plus randomized traffic
// scored against an arithmetic LOA reference model.
module tb_approx_add_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready, stat_clr;
   logic [15:0] in_a, in_b;
   logic [3:0]  in_k;
   logic [16:0] out_sum, out_err, err_max;
   logic [15:0] err_cnt;

   approx_add_pipe #(
      .WIDTH (16),
      .STAGES(2),
      .KMAX  (8),
      .CNT_W (16)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_a     (in_a),
      .in_b     (in_b),
      .in_k     (in_k),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_sum  (out_sum),
      .out_err  (out_err),
      .stat_clr (stat_clr),
      .err_max  (err_max),
      .err_cnt  (err_cnt)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [16:0] sum_q[$];
   logic [16:0] err_q[$];
   logic [16:0] m_max = '0;
   logic [15:0] m_cnt = '0;
   logic [16:0] last_sum, last_err;
   bit          stalled_prev = 1'b0;
   bit          last_in_fire = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // LOA from plain arithmetic: OR'd low field plus shifted upper add with injected carry.
   function automatic logic [16:0] ref_sum(input logic [15:0] a, input logic [15:0] b,
                                           input logic [3:0] k);
      int unsigned kk, ai, bi, lo, c, hi;
      kk = (k > 4'd8) ? 8 : 32'(k);
      ai = 32'(a);
      bi = 32'(b);
      lo = (ai | bi) & ((32'd1 << kk) - 1);
      c  = (kk > 0) ? (((ai >> (kk - 1)) & (bi >> (kk - 1))) & 1) : 0;
      hi = ((ai >> kk) + (bi >> kk) + c) << kk;
      return 17'(hi | lo);
   endfunction

   function automatic logic [16:0] ref_err(input logic [15:0] a, input logic [15:0] b,
                                           input logic [3:0] k);
      int unsigned ex, ap;
      ex = 32'(a) + 32'(b);
      ap = 32'(ref_sum(a, b, k));
      return 17'((ex >= ap) ? ex - ap : ap - ex);
   endfunction

   // One clock: check the output side before the edge, update the model after it.
   task automatic tick();
      bit          in_fire, out_fire;
      logic [15:0] ca, cb;
      logic [3:0]  ck;
      logic [16:0] e;
      #1;
      in_fire  = in_valid && in_ready;
      out_fire = out_valid && out_ready;
      ca = in_a;
      cb = in_b;
      ck = in_k;
      if (stalled_prev) begin
         chk("stall_valid", 32'(out_valid), 32'(1));
         if (sum_q.size() > 0) begin
            chk("stall_sum", 32'(out_sum), 32'(sum_q[0]));
            chk("stall_err", 32'(out_err), 32'(err_q[0]));
         end
      end
      if (out_fire) begin
         chk("sb_nonempty", 32'(sum_q.size() > 0), 32'(1));
         if (sum_q.size() > 0) begin
            chk("out_sum", 32'(out_sum), 32'(sum_q[0]));
            chk("out_err", 32'(out_err), 32'(err_q[0]));
         end
         last_sum = out_sum;
         last_err = out_err;
      end
      stalled_prev = out_valid && !out_ready;
      @(posedge clk);
      #1;
      if (in_fire) begin
         sum_q.push_back(ref_sum(ca, cb, ck));
         err_q.push_back(ref_err(ca, cb, ck));
      end
      if (out_fire && sum_q.size() > 0) begin
         void'(sum_q.pop_front());
         e = err_q.pop_front();
         if (e > m_max) m_max = e;
         if (e != 0 && m_cnt != 16'hFFFF) m_cnt++;
      end
      if (stat_clr) begin
         m_max = '0;
         m_cnt = '0;
      end
      chk("err_max", 32'(err_max), 32'(m_max));
      chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
      last_in_fire = in_fire;
      @(negedge clk);
   endtask

   task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [3:0] k);
      in_a     = a;
      in_b     = b;
      in_k     = k;
      in_valid = 1'b1;
      for (int t = 0; t < 20; t++) begin
         tick();
         if (last_in_fire) break;
      end
      chk("send_accept", 32'(last_in_fire), 32'(1));
      in_valid = 1'b0;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      in_valid  = 1'b0;
      for (int t = 0; t < 20; t++) begin
         if (sum_q.size() == 0 && !out_valid) break;
         tick();
      end
      chk("drain_empty", 32'(sum_q.size()), 32'(0));
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      stat_clr  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_k      = '0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'(0));
      chk("rst_out_sum", 32'(out_sum), 32'(0));
      chk("rst_out_err", 32'(out_err), 32'(0));
      chk("rst_err_max", 32'(err_max), 32'(0));
      chk("rst_err_cnt", 32'(err_cnt), 32'(0));
      chk("rst_in_ready", 32'(in_ready), 32'(1));
      rst_n = 1'b1;
      @(negedge clk);

      // Exact mode and two-cycle latency.
      send(16'hFFFF, 16'h0001, 4'd0);
      chk("lat_edge1", 32'(out_valid), 32'(0));
      tick();
      chk("lat_edge2", 32'(out_valid), 32'(1));
      tick();
      chk("exact_sum", 32'(last_sum), 32'h10000);
      chk("exact_err", 32'(last_err), 32'(0));
      chk("exact_cnt", 32'(err_cnt), 32'(0));

      // LOA without injected carry.
      send(16'h000F, 16'h0001, 4'd4);
      drain();
      chk("loa_sum", 32'(last_sum), 32'h0000F);
      chk("loa_err", 32'(last_err), 32'(1));
      chk("loa_cnt", 32'(err_cnt), 32'(1));
      chk("loa_max", 32'(err_max), 32'(1));

      // LOA with carry, then clamped k.
      send(16'h0008, 16'h0008, 4'd4);
      drain();
      chk("carry_sum", 32'(last_sum), 32'h00018);
      chk("carry_err", 32'(last_err), 32'(8));
      chk("carry_max", 32'(err_max), 32'(8));
      send(16'h0008, 16'h0008, 4'd12);
      drain();
      chk("clamp_sum", 32'(last_sum), 32'h00008);
      chk("clamp_err", 32'(last_err), 32'(8));

      // Backpressure: fill the pipe, stall, then release.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_a = 16'h1234; in_b = 16'h00FF; in_k = 4'd3;
      tick();
      chk("bp_acc0", 32'(last_in_fire), 32'(1));
      in_a = 16'hABCD; in_b = 16'h1111; in_k = 4'd8;
      tick();
      chk("bp_acc1", 32'(last_in_fire), 32'(1));
      in_a = 16'h8000; in_b = 16'h8000; in_k = 4'd0;
      tick();
      tick();
      tick();
      chk("bp_in_ready_low", 32'(in_ready), 32'(0));
      chk("bp_held_valid", 32'(out_valid), 32'(1));
      out_ready = 1'b1;
      send(16'h8000, 16'h8000, 4'd0);
      send(16'h0F0F, 16'hF0F0, 4'd5);
      drain();

      // Randomized traffic with random backpressure and occasional clears.
      for (int n = 0; n < 400; n++) begin
         in_a      = 16'($urandom);
         in_b      = 16'($urandom);
         in_k      = 4'($urandom_range(0, 15));
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         stat_clr  = ($urandom_range(0, 31) == 0);
         tick();
      end
      stat_clr = 1'b0;
      drain();

      // stat_clr coinciding with an erroring transfer.
      send(16'h00FF, 16'h00FF, 4'd8);
      drain();
      chk("pre_clr_cnt_nz", 32'(err_cnt != 0), 32'(1));
      out_ready = 1'b0;
      send(16'h000F, 16'h0001, 4'd4);
      tick();
      chk("clr_valid", 32'(out_valid), 32'(1));
      stat_clr  = 1'b1;
      out_ready = 1'b1;
      tick();
      stat_clr = 1'b0;
      chk("clr_cnt", 32'(err_cnt), 32'(0));
      chk("clr_max", 32'(err_max), 32'(0));

      // Reset with two beats in flight.
      send(16'h000F, 16'h0001, 4'd4);
      send(16'h0008, 16'h0008, 4'd4);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 32'(0));
      chk("mid_rst_max", 32'(err_max), 32'(0));
      chk("mid_rst_cnt", 32'(err_cnt), 32'(0));
      sum_q.delete();
      err_q.delete();
      m_max        = '0;
      m_cnt        = '0;
      stalled_prev = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      send(16'h00F0, 16'h0F10, 4'd6);
      drain();
      chk("post_rst_sum", 32'(last_sum), 32'(ref_sum(16'h00F0, 16'h0F10, 4'd6)));

      // Saturating error counter.
      stat_clr = 1'b1;
      tick();
      stat_clr  = 1'b0;
      out_ready = 1'b1;
      in_a = 16'h000F; in_b = 16'h0001; in_k = 4'd4;
      in_valid = 1'b1;
      for (int i = 0; i < 65539; i++) tick();
      drain();
      chk("sat_cnt", 32'(err_cnt), 32'h0000FFFF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
